rr_grant_arbiter4: RTL and testbench

- Round-robin arbiter that shares a single 4-slot resource between four requesters.
- Produces a registered one-hot grant plus its 2-bit encoded index and valid flag, using the same one-hot-to-index mapping as the team's 4-to-2 encoder.
- An owner keeps the grant while it holds its request, up to MAX_HOLD cycles when others are waiting. After that, rotation is forced.
- Sits between requesting agents and the shared datapath select logic.

---
 rtl/rr_grant_arbiter4.sv | 145 ++++++++++++++
 tb/tb_rr_grant_arbiter4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_arbiter4
//  Description : Four-requester round-robin arbiter with a registered one-hot
//                grant, encoded index, valid flag and a hold limit that forces
//                rotation when an owner keeps the grant while others wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [7:0] r_hold_cnt;
  logic [3:0] r_grant;
  logic [1:0] r_grant_idx;
  logic       r_grant_valid;
  logic       r_timeout;

  state_t     w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [1:0] w_owner_nxt;
  logic [7:0] w_hold_cnt_nxt;
  logic       w_active_nxt;
  logic       w_timeout_nxt;
  logic [2:0] w_pick;
  logic [3:0] w_owner_oh;
  logic [3:0] w_others;
  logic [1:0] w_after_owner;

  // Scan v starting at index s (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] s);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Descending offset so the closest hit to s is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_owner_oh    = 4'b0001 << r_owner;
  assign w_others      = req & ~w_owner_oh;
  assign w_after_owner = r_owner + 2'd1;

  // Next-state, next-owner and hold-count selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_hold_cnt_nxt = r_hold_cnt;
    w_active_nxt   = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_pick         = 3'b000;
    case (r_state)
      ST_IDLE: begin
        w_pick = rr_pick(req, r_ptr);
        if (w_pick[2]) begin
          w_state_nxt    = ST_GRANT;
          w_owner_nxt    = w_pick[1:0];
          w_hold_cnt_nxt = 8'd1;
          w_active_nxt   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req[r_owner]) begin
          // Owner released; a waiting requester takes over without a bubble.
          w_pick    = rr_pick(req, w_after_owner);
          w_ptr_nxt = w_after_owner;
          if (w_pick[2]) begin
            w_owner_nxt    = w_pick[1:0];
            w_hold_cnt_nxt = 8'd1;
            w_active_nxt   = 1'b1;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_hold_cnt_nxt = 8'd0;
          end
        end else if ((r_hold_cnt >= c_max_hold) && (w_others != 4'b0000)) begin
          // Hold limit reached with competitors present: preempt the owner.
          w_pick         = rr_pick(w_others, w_after_owner);
          w_ptr_nxt      = w_after_owner;
          w_owner_nxt    = w_pick[1:0];
          w_hold_cnt_nxt = 8'd1;
          w_active_nxt   = 1'b1;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_active_nxt = 1'b1;
          if (r_hold_cnt < c_max_hold) w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 2'd0;
      r_owner       <= 2'd0;
      r_hold_cnt    <= 8'd0;
      r_grant       <= 4'b0000;
      r_grant_idx   <= 2'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_owner       <= w_owner_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_grant       <= w_active_nxt ? (4'b0001 << w_owner_nxt) : 4'b0000;
      r_grant_idx   <= w_active_nxt ? w_owner_nxt : 2'd0;
      r_grant_valid <= w_active_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_arbiter4
//  Description : Directed self-checking bench for rr_grant_arbiter4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_grant_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed and expected are packed {timeout, valid, idx[1:0], grant[3:0]}.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b (to,valid,idx,grant)", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic v, input logic to);
    check(tag, {timeout, grant_valid, grant_idx, grant}, {to, v, idx, g});
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check cleared outputs, release away from a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #3;
    expect_out("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset and idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // Single requester holds indefinitely, no timeout.
    req = 4'b0100;
    tick();
    expect_out("single_first", 4'b0100, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("single_hold", 4'b0100, 2'b10, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_out("single_drop", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Round-robin fairness with back-to-back handoffs.
    do_reset();
    req = 4'b1111;
    tick();
    expect_out("rr_0", 4'b0001, 2'b00, 1'b1, 1'b0);
    req = 4'b1110;
    tick();
    expect_out("rr_1", 4'b0010, 2'b01, 1'b1, 1'b0);
    req = 4'b1101;
    tick();
    expect_out("rr_2", 4'b0100, 2'b10, 1'b1, 1'b0);
    req = 4'b1011;
    tick();
    expect_out("rr_3", 4'b1000, 2'b11, 1'b1, 1'b0);
    req = 4'b0111;
    tick();
    expect_out("rr_wrap", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Forced rotation at MAX_HOLD=8.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("force_own0", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    tick();
    expect_out("force_to1", 4'b0010, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_out("force_own1", 4'b0010, 2'b01, 1'b1, 1'b0);
    end
    tick();
    expect_out("force_to0", 4'b0001, 2'b00, 1'b1, 1'b1);
    tick();
    expect_out("force_after", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Pointer wrap: owner 3 releases, requester 0 wins over 1.
    do_reset();
    req = 4'b1000;
    tick();
    expect_out("wrap_own3", 4'b1000, 2'b11, 1'b1, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("wrap_next", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Asynchronous reset between edges while grant=0010 is active.
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("async_pre", 4'b0010, 2'b01, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_clear", 4'b0000, 2'b00, 1'b0, 1'b0);
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_out("async_first", 4'b0010, 2'b01, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
